// File: rtl/toggle_mon_pkg.sv
// toggle_mon_pkg: shared state encoding and width constants for the T flip-flop monitor.
package toggle_mon_pkg;
  typedef enum logic [1:0] {IDLE, TRACK, FAULT} state_e;
  localparam int CNT_W_DEF = 16;
  localparam int ERR_W = 8;
endpackage

// File: rtl/toggle_mon_edge.sv
// toggle_mon_edge: registers the observed q and t and derives edge strobes against the previous q.
module toggle_mon_edge (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic q_i,
  input  logic t_i,
  output logic q_prev_o,
  output logic t_prev_o,
  output logic any_edge_o,
  output logic rise_o
);
  logic q_prev_q, t_prev_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      q_prev_q <= 1'b0;
      t_prev_q <= 1'b0;
    end else begin
      q_prev_q <= clr_i ? 1'b0 : q_i;
      t_prev_q <= clr_i ? 1'b0 : t_i;
    end
  assign q_prev_o   = q_prev_q;
  assign t_prev_o   = t_prev_q;
  assign any_edge_o = q_i ^ q_prev_q;
  assign rise_o     = q_i & ~q_prev_q;
endmodule

// File: rtl/toggle_mon.sv
// toggle_mon: checks an upstream T flip-flop against q_prev^t_prev, counts toggles and errors,
// and (with TOGGLE_MON_PERIOD_EN defined) measures the clk period between rising edges of q.
module toggle_mon
  import toggle_mon_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int ERR_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             q,
  input  logic             t,
  input  logic             clr,
  output logic [CNT_W-1:0] toggle_cnt,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_cnt,
  output logic             fault,
  output logic [CNT_W-1:0] period,
  output logic             period_vld
);
  localparam logic [ERR_W-1:0] LIMIT = ERR_W'(ERR_LIMIT);
  state_e state_q, state_d;
  logic [CNT_W-1:0] tog_q, tog_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic mm_q, mm_d, active, mm, q_prev, t_prev, any_edge, rise;
  toggle_mon_edge u_edge (
    .clk(clk), .rst(rst), .clr_i(clr), .q_i(q), .t_i(t),
    .q_prev_o(q_prev), .t_prev_o(t_prev), .any_edge_o(any_edge), .rise_o(rise)
  );
  always_comb begin
    active  = state_q != IDLE;
    mm      = active && (q != (q_prev ^ t_prev));
    mm_d    = !clr && mm;
    err_d   = clr ? '0 : mm ? err_q + ERR_W'(err_q != '1) : err_q;
    tog_d   = clr ? '0 : (active && any_edge) ? tog_q + CNT_W'(1) : tog_q;
    state_d = clr ? IDLE
            : state_q == IDLE ? TRACK
            : (state_q == TRACK && err_d >= LIMIT) ? FAULT : state_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      tog_q   <= '0;
      err_q   <= '0;
      mm_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tog_q   <= tog_d;
      err_q   <= err_d;
      mm_q    <= mm_d;
    end
  assign toggle_cnt = tog_q;
  assign err_cnt    = err_q;
  assign mismatch   = mm_q;
  assign fault      = state_q == FAULT;
`ifdef TOGGLE_MON_PERIOD_EN
  logic [CNT_W-1:0] pcnt_q, pcnt_d, per_q, per_d;
  logic seen_q, seen_d, vld_q, vld_d;
  // The first rise after leaving IDLE only arms the counter; a period needs two rises.
  always_comb begin
    pcnt_d = (clr || !active) ? '0 : rise ? CNT_W'(1) : pcnt_q + CNT_W'(pcnt_q != '1);
    seen_d = !clr && active && (seen_q || rise);
    vld_d  = !clr && active && rise && seen_q;
    per_d  = clr ? '0 : vld_d ? pcnt_q : per_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pcnt_q <= '0;
      per_q  <= '0;
      seen_q <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      pcnt_q <= pcnt_d;
      per_q  <= per_d;
      seen_q <= seen_d;
      vld_q  <= vld_d;
    end
  assign period     = per_q;
  assign period_vld = vld_q;
`else
  logic unused_rise;
  assign unused_rise = rise;
  assign period      = '0;
  assign period_vld  = 1'b0;
`endif
endmodule

// File: tb/tb_toggle_mon.sv
// tb_toggle_mon: directed self-checking bench for toggle_mon with default parameters.
module tb_toggle_mon;
  logic clk = 1'b0, rst = 1'b1, q = 1'b0, t = 1'b0, clr = 1'b0;
  logic [15:0] toggle_cnt, period;
  logic [7:0] err_cnt;
  logic mismatch, fault, period_vld;
  int total = 0, bad = 0;
`ifdef TOGGLE_MON_PERIOD_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif
  localparam logic [15:0] PER2 = PEN ? 16'd2 : 16'd0;

  toggle_mon dut (
    .clk(clk), .rst(rst), .q(q), .t(t), .clr(clr),
    .toggle_cnt(toggle_cnt), .mismatch(mismatch), .err_cnt(err_cnt),
    .fault(fault), .period(period), .period_vld(period_vld)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; q = 1'b0; t = 1'b0; clr = 1'b0;
    tick;
    tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    total++;
    if ({toggle_cnt, mismatch, err_cnt, fault, period, period_vld} !== '0) begin
      bad++;
      $display("FAIL reset outputs got tog=%0d mm=%b err=%0d flt=%b per=%0d vld=%b want all 0",
               toggle_cnt, mismatch, err_cnt, fault, period, period_vld);
    end
    rst = 1'b0;
  endtask

  task automatic test_track;
    do_reset;
    t = 1'b1;
    tick;
    total++;
    if (toggle_cnt !== 16'd0 || mismatch !== 1'b0) begin
      bad++;
      $display("FAIL idle_exit got tog=%0d mm=%b want 0 0", toggle_cnt, mismatch);
    end
    q = q ^ t;
    for (int k = 1; k <= 20; k++) begin
      tick;
      total++;
      if (toggle_cnt !== 16'(k)) begin
        bad++;
        $display("FAIL track_tog k=%0d got %0d want %0d", k, toggle_cnt, k);
      end
      total++;
      if (mismatch !== 1'b0) begin
        bad++;
        $display("FAIL track_mm k=%0d got %b want 0", k, mismatch);
      end
      total++;
      if (period_vld !== (PEN && (k % 2 == 1) && k >= 3)) begin
        bad++;
        $display("FAIL track_vld k=%0d got %b want %b", k, period_vld, PEN && (k % 2 == 1) && k >= 3);
      end
      q = q ^ t;
    end
    total++;
    if (period !== PER2) begin
      bad++;
      $display("FAIL track_period got %0d want %0d", period, PER2);
    end
  endtask

  task automatic test_hold;
    t = 1'b0;
    tick;
    total++;
    if (toggle_cnt !== 16'd21 || mismatch !== 1'b0 || period_vld !== PEN) begin
      bad++;
      $display("FAIL hold_last_rise got tog=%0d mm=%b vld=%b want 21 0 %b", toggle_cnt, mismatch, period_vld, PEN);
    end
    q = q ^ t;
    for (int k = 1; k <= 50; k++) begin
      tick;
      total++;
      if (toggle_cnt !== 16'd21 || mismatch !== 1'b0 || period_vld !== 1'b0) begin
        bad++;
        $display("FAIL hold k=%0d got tog=%0d mm=%b vld=%b want 21 0 0", k, toggle_cnt, mismatch, period_vld);
      end
      q = q ^ t;
    end
    total++;
    if (period !== PER2) begin
      bad++;
      $display("FAIL hold_period got %0d want %0d", period, PER2);
    end
  endtask

  task automatic test_fault;
    do_reset;
    t = 1'b1;
    tick;
    for (int k = 1; k <= 260; k++) begin
      tick;
      total++;
      if (mismatch !== 1'b1) begin
        bad++;
        $display("FAIL fault_mm k=%0d got %b want 1", k, mismatch);
      end
      total++;
      if (err_cnt !== 8'(k > 255 ? 255 : k)) begin
        bad++;
        $display("FAIL fault_err k=%0d got %0d want %0d", k, err_cnt, k > 255 ? 255 : k);
      end
      total++;
      if (fault !== (k >= 4)) begin
        bad++;
        $display("FAIL fault_flag k=%0d got %b want %b", k, fault, k >= 4);
      end
    end
    total++;
    if (toggle_cnt !== 16'd0) begin
      bad++;
      $display("FAIL fault_tog got %0d want 0", toggle_cnt);
    end
  endtask

  task automatic test_clr;
    clr = 1'b1;
    tick;
    total++;
    if ({toggle_cnt, mismatch, err_cnt, fault, period, period_vld} !== '0) begin
      bad++;
      $display("FAIL clr outputs got tog=%0d mm=%b err=%0d flt=%b per=%0d vld=%b want all 0",
               toggle_cnt, mismatch, err_cnt, fault, period, period_vld);
    end
    clr = 1'b0; q = 1'b1; t = 1'b0;
    tick;
    total++;
    if (mismatch !== 1'b0 || err_cnt !== 8'd0 || toggle_cnt !== 16'd0) begin
      bad++;
      $display("FAIL clr_idle got mm=%b err=%0d tog=%0d want 0 0 0", mismatch, err_cnt, toggle_cnt);
    end
    tick;
    total++;
    if (mismatch !== 1'b0 || toggle_cnt !== 16'd0) begin
      bad++;
      $display("FAIL clr_track_ok got mm=%b tog=%0d want 0 0", mismatch, toggle_cnt);
    end
    q = 1'b0;
    tick;
    total++;
    if (mismatch !== 1'b1 || err_cnt !== 8'd1 || toggle_cnt !== 16'd1 || fault !== 1'b0) begin
      bad++;
      $display("FAIL clr_recheck got mm=%b err=%0d tog=%0d flt=%b want 1 1 1 0", mismatch, err_cnt, toggle_cnt, fault);
    end
  endtask

  task automatic test_async_rst;
    do_reset;
    t = 1'b1;
    tick;
    q = q ^ t;
    for (int k = 1; k <= 5; k++) begin
      tick;
      q = q ^ t;
    end
    total++;
    if (toggle_cnt !== 16'd5 || period !== PER2) begin
      bad++;
      $display("FAIL pre_rst got tog=%0d per=%0d want 5 %0d", toggle_cnt, period, PER2);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({toggle_cnt, mismatch, err_cnt, fault, period, period_vld} !== '0) begin
      bad++;
      $display("FAIL async_rst got tog=%0d mm=%b err=%0d flt=%b per=%0d vld=%b want all 0",
               toggle_cnt, mismatch, err_cnt, fault, period, period_vld);
    end
    #2 rst = 1'b0;
    q = 1'b0; t = 1'b1;
    tick;
    q = q ^ t;
    for (int k = 1; k <= 3; k++) begin
      tick;
      total++;
      if (toggle_cnt !== 16'(k) || mismatch !== 1'b0) begin
        bad++;
        $display("FAIL post_rst k=%0d got tog=%0d mm=%b want %0d 0", k, toggle_cnt, mismatch, k);
      end
      total++;
      if (period_vld !== (PEN && k == 3) || period !== (k == 3 ? PER2 : 16'd0)) begin
        bad++;
        $display("FAIL post_rst_period k=%0d got vld=%b per=%0d want %b %0d",
                 k, period_vld, period, PEN && k == 3, k == 3 ? PER2 : 16'd0);
      end
      q = q ^ t;
    end
  endtask

  initial begin
    test_reset;
    test_track;
    test_hold;
    test_fault;
    test_clr;
    test_async_rst;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
